// File: rtl/l2_mshr_pkg.sv
// Shared types and default widths for the L2 miss-status holding register file.
package l2_mshr_pkg;

    // Entry count of the fixed-depth request buffer this block replaces.
    localparam int N_REQS      = 4;
    localparam int SET_W       = 9;
    localparam int TAG_W       = 15;
    localparam int WAY_W       = 3;
    localparam int STATE_W     = 4;
    localparam int INVACK_W    = 4;

    // Signed ack counter: one extra bit so early InvAcks can drive it negative.
    typedef logic signed [INVACK_W:0] ack_cnt_t;

    // Entry layout at the default widths.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [SET_W-1:0]   set_idx;
        logic [WAY_W-1:0]   way;
        logic [STATE_W-1:0] state;
        logic               data_rcvd;
        ack_cnt_t           ack_cnt;
    } mshr_entry_t;

endpackage

// File: rtl/l2_mshr_if.sv
// Decoder-facing bus of the MSHR file; master = L2 decoder/FSM, slave = MSHR.
interface l2_mshr_if
    import l2_mshr_pkg::*;
#(
    parameter int N_ENTRIES   = N_REQS,
    parameter int SET_BITS    = SET_W,
    parameter int TAG_BITS    = TAG_W,
    parameter int WAY_BITS    = WAY_W,
    parameter int STATE_BITS  = STATE_W,
    parameter int INVACK_BITS = INVACK_W
);
    localparam int IDX_BITS = $clog2(N_ENTRIES);
    localparam int CNT_BITS = $clog2(N_ENTRIES + 1);

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [TAG_BITS-1:0]    alloc_tag;
    logic [SET_BITS-1:0]    alloc_set;
    logic [WAY_BITS-1:0]    alloc_way;
    logic [STATE_BITS-1:0]  alloc_state;
    logic [IDX_BITS-1:0]    alloc_idx;
    logic [TAG_BITS-1:0]    lkp_tag;
    logic [SET_BITS-1:0]    lkp_set;
    logic                   lkp_hit;
    logic [IDX_BITS-1:0]    lkp_hit_idx;
    logic                   set_conflict;
    logic                   upd_valid;
    logic [IDX_BITS-1:0]    upd_idx;
    logic [STATE_BITS-1:0]  upd_state;
    logic                   ack_add_valid;
    logic [IDX_BITS-1:0]    ack_add_idx;
    logic [INVACK_BITS-1:0] ack_add_val;
    logic                   ack_dec_valid;
    logic [IDX_BITS-1:0]    ack_dec_idx;
    logic                   free_valid;
    logic [IDX_BITS-1:0]    free_idx;
    logic [IDX_BITS-1:0]    rd_idx;
    logic [STATE_BITS-1:0]  rd_state;
    logic [WAY_BITS-1:0]    rd_way;
    logic [TAG_BITS-1:0]    rd_tag;
    logic                   done_valid;
    logic [IDX_BITS-1:0]    done_idx;
    logic [CNT_BITS-1:0]    cnt;
    logic                   full;
    logic                   empty;
    logic                   err;

    modport master (
        output alloc_valid, alloc_tag, alloc_set, alloc_way, alloc_state,
               lkp_tag, lkp_set, upd_valid, upd_idx, upd_state,
               ack_add_valid, ack_add_idx, ack_add_val, ack_dec_valid, ack_dec_idx,
               free_valid, free_idx, rd_idx,
        input  alloc_ready, alloc_idx, lkp_hit, lkp_hit_idx, set_conflict,
               rd_state, rd_way, rd_tag, done_valid, done_idx, cnt, full, empty, err
    );

    modport slave (
        input  alloc_valid, alloc_tag, alloc_set, alloc_way, alloc_state,
               lkp_tag, lkp_set, upd_valid, upd_idx, upd_state,
               ack_add_valid, ack_add_idx, ack_add_val, ack_dec_valid, ack_dec_idx,
               free_valid, free_idx, rd_idx,
        output alloc_ready, alloc_idx, lkp_hit, lkp_hit_idx, set_conflict,
               rd_state, rd_way, rd_tag, done_valid, done_idx, cnt, full, empty, err
    );
endinterface

// File: rtl/l2_mshr_prio_enc.sv
// Lowest-index-wins priority encoder; found=0 leaves idx at 0.
module l2_mshr_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);
    // Scan from the top so the lowest requesting index is the last write.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/l2_mshr.sv
// MSHR file: allocation, address lookup, signed InvAck counting, completion pulses.
module l2_mshr
    import l2_mshr_pkg::*;
#(
    parameter int N_ENTRIES   = N_REQS,
    parameter int SET_BITS    = SET_W,
    parameter int TAG_BITS    = TAG_W,
    parameter int WAY_BITS    = WAY_W,
    parameter int STATE_BITS  = STATE_W,
    parameter int INVACK_BITS = INVACK_W
) (
    input  logic     clk,
    input  logic     rst,
    l2_mshr_if.slave bus
);
    localparam int IDX_BITS = $clog2(N_ENTRIES);
    localparam int CNT_BITS = $clog2(N_ENTRIES + 1);
    localparam int CW       = INVACK_BITS + 1;

    // Same layout as mshr_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [SET_BITS-1:0]   set_idx;
        logic [WAY_BITS-1:0]   way;
        logic [STATE_BITS-1:0] state;
        logic                  data_rcvd;
        logic [CW-1:0]         ack_cnt;
    } entry_t;

    entry_t [N_ENTRIES-1:0] ent_q, ent_d;
    logic [N_ENTRIES-1:0]   valid_q, valid_d, pend_q, pend_d;
    logic [N_ENTRIES-1:0]   hit_vec, conf_vec, comp_vec, req_vec;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   err_q, err_d, done_valid_q, done_valid_d;
    logic [IDX_BITS-1:0]    done_idx_q, done_idx_d, alloc_idx_w, req_idx;
    logic                   alloc_found, req_found, fire, free_ok;
    logic                   add_i, dec_i, data_i;
    logic [CW:0]            sum;

    l2_mshr_prio_enc #(.N(N_ENTRIES)) u_alloc_enc (.req(~valid_q), .found(alloc_found), .idx(alloc_idx_w));
    l2_mshr_prio_enc #(.N(N_ENTRIES)) u_hit_enc   (.req(hit_vec),  .found(bus.lkp_hit), .idx(bus.lkp_hit_idx));
    l2_mshr_prio_enc #(.N(N_ENTRIES)) u_done_enc  (.req(req_vec),  .found(req_found),   .idx(req_idx));

    assign bus.alloc_ready  = alloc_found;
    assign bus.alloc_idx    = alloc_idx_w;
    assign bus.set_conflict = |conf_vec;
    assign bus.rd_state     = ent_q[bus.rd_idx].state;
    assign bus.rd_way       = ent_q[bus.rd_idx].way;
    assign bus.rd_tag       = ent_q[bus.rd_idx].tag;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_idx     = done_idx_q;
    assign bus.cnt          = cnt_q;
    assign bus.full         = (cnt_q == CNT_BITS'(N_ENTRIES));
    assign bus.empty        = (cnt_q == '0);
    assign bus.err          = err_q;

    // Address match against registered contents only.
    always_comb begin
        hit_vec  = '0;
        conf_vec = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            conf_vec[i] = valid_q[i] && (ent_q[i].set_idx == bus.lkp_set);
            hit_vec[i]  = conf_vec[i] && (ent_q[i].tag == bus.lkp_tag);
        end
    end

    // Next entry contents: update, ack counting, free, then allocation.
    always_comb begin
        ent_d    = ent_q;
        valid_d  = valid_q;
        comp_vec = '0;
        err_d    = err_q;
        add_i    = 1'b0;
        dec_i    = 1'b0;
        data_i   = 1'b0;
        sum      = '0;
        fire     = bus.alloc_valid && alloc_found;
        free_ok  = bus.free_valid && valid_q[bus.free_idx];
        if (bus.free_valid && !valid_q[bus.free_idx]) err_d = 1'b1;
        if (bus.upd_valid) begin
            if (!valid_q[bus.upd_idx]) err_d = 1'b1;
            else if (!(bus.free_valid && bus.free_idx == bus.upd_idx))
                ent_d[bus.upd_idx].state = bus.upd_state;
        end
        for (int i = 0; i < N_ENTRIES; i++) begin
            add_i = bus.ack_add_valid && (bus.ack_add_idx == IDX_BITS'(i));
            dec_i = bus.ack_dec_valid && (bus.ack_dec_idx == IDX_BITS'(i));
            if ((add_i || dec_i) && valid_q[i]) begin
                if (bus.free_valid && bus.free_idx == IDX_BITS'(i)) begin
                    err_d = 1'b1;
                end else begin
                    // One guard bit catches wrap of the signed counter.
                    sum = {ent_q[i].ack_cnt[CW-1], ent_q[i].ack_cnt}
                        + (add_i ? {2'b00, bus.ack_add_val} : '0)
                        - (CW+1)'(dec_i);
                    if (sum[CW] != sum[CW-1]) err_d = 1'b1;
                    data_i             = ent_q[i].data_rcvd || add_i;
                    ent_d[i].ack_cnt   = sum[CW-1:0];
                    ent_d[i].data_rcvd = data_i;
                    comp_vec[i]        = data_i && (sum[CW-1:0] == '0);
                end
            end
        end
        if (free_ok) valid_d[bus.free_idx] = 1'b0;
        if (fire) begin
            valid_d[alloc_idx_w] = 1'b1;
            ent_d[alloc_idx_w]   = '{tag: bus.alloc_tag, set_idx: bus.alloc_set, way: bus.alloc_way,
                                     state: bus.alloc_state, data_rcvd: 1'b0, ack_cnt: '0};
        end
        cnt_d = cnt_q + CNT_BITS'(fire) - CNT_BITS'(free_ok);
    end

    // Done arbitration: lowest completer reports, the rest wait (dropped if freed).
    always_comb begin
        req_vec      = comp_vec | (pend_q & valid_q & valid_d);
        done_valid_d = req_found;
        done_idx_d   = req_idx;
        pend_d       = req_vec;
        if (req_found) pend_d[req_idx] = 1'b0;
    end

    // State registers; reset discards entries and any pending completions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q        <= '0;
            valid_q      <= '0;
            pend_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_idx_q   <= '0;
        end else begin
            ent_q        <= ent_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_idx_q   <= done_idx_d;
        end
    end
endmodule
